matmul_result_drain: RTL and testbench

//  Downstream of the matmul core. Snapshots the M x N accumulator matrix C on the core's done pulse.

---
 rtl/matmul_pkg.sv | 16 +
 rtl/matmul_result_drain_if.sv | 15 +
 rtl/result_width_conv.sv | 39 +++
 rtl/matmul_result_drain.sv | 129 ++++++++++++
 tb/tb_matmul_result_drain.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matmul result drain path.
package matmul_pkg;

  localparam int DEF_ACC_W = 32;
  localparam int DEF_OUT_W = 32;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } drain_state_e;

  function automatic int idx_w(input int m, input int n);
    return $clog2(m * n) + 1;
  endfunction

endpackage

// File: rtl/matmul_result_drain_if.sv
// Valid/ready result stream from the drain toward the AXI write side.
interface matmul_result_drain_if #(
  parameter int OUT_W = 32,
  parameter int IDX_W = 3
);
  logic                    m_valid;
  logic                    m_ready;
  logic signed [OUT_W-1:0] m_data;
  logic                    m_last;
  logic [IDX_W-1:0]        m_idx;
  logic                    sat_o;

  modport master (output m_valid, m_data, m_last, m_idx, sat_o, input m_ready);
  modport slave  (input m_valid, m_data, m_last, m_idx, sat_o, output m_ready);
endinterface

// File: rtl/result_width_conv.sv
// Narrows one accumulator element to the stream width.
// RESULT_SAT_EN selects signed saturation; otherwise the upper bits are truncated.
module result_width_conv #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 32
) (
  input  logic [ACC_W-1:0] acc,
  output logic [OUT_W-1:0] data,
  output logic             sat
);

`ifdef RESULT_SAT_EN
  localparam logic [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MIN_V = ~MAX_V;

  // Clamp to the signed range representable in OUT_W bits
  always_comb begin
    data = acc[OUT_W-1:0];
    sat  = 1'b0;
    if ($signed(acc) > $signed(MAX_V)) begin
      data = MAX_V[OUT_W-1:0];
      sat  = 1'b1;
    end else if ($signed(acc) < $signed(MIN_V)) begin
      data = MIN_V[OUT_W-1:0];
      sat  = 1'b1;
    end else begin
      data = acc[OUT_W-1:0];
      sat  = 1'b0;
    end
  end
`else
  logic unused_hi_s;

  assign data        = acc[OUT_W-1:0];
  assign sat         = 1'b0;
  assign unused_hi_s = ^acc;
`endif

endmodule

// File: rtl/matmul_result_drain.sv
// Snapshots the core's C matrix on done_i and drains it row-major onto a stream.
// Optional saturation via the RESULT_SAT_EN macro (see result_width_conv).
module matmul_result_drain
  import matmul_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int M     = 2,
  parameter int N     = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               done_i,
  input  logic signed [M-1:0][N-1:0][ACC_W-1:0] C,
  output logic                               busy,
  output logic                               overflow,
  matmul_result_drain_if.master              m
);

  localparam int NUM   = M * N;
  localparam int IDX_W = idx_w(M, N);
  localparam int SEL_W = IDX_W - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);
  localparam logic [0:0] ST_IDLE   = IDLE;
  localparam logic [0:0] ST_STREAM = STREAM;

  logic [0:0]                state_r;
  logic [NUM-1:0][ACC_W-1:0] snap_r;
  logic [IDX_W-1:0]          idx_r;
  logic                      valid_r;
  logic                      last_r;
  logic                      busy_r;
  logic                      ovf_r;

  logic                      hs_s;
  logic                      final_s;
  logic [IDX_W-1:0]          idx_nxt_s;
  logic [ACC_W-1:0]          elem_s;
  logic [OUT_W-1:0]          data_s;
  logic                      sat_s;

  // Handshake decode and current snapshot element
  always_comb begin
    hs_s      = valid_r && m.m_ready;
    final_s   = hs_s && last_r;
    idx_nxt_s = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
    elem_s    = snap_r[idx_r[SEL_W-1:0]];
  end

  // Drain FSM, index counter, snapshot and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      snap_r  <= '0;
      idx_r   <= '0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      busy_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (done_i) begin
            snap_r  <= C;
            state_r <= ST_STREAM;
            idx_r   <= '0;
            valid_r <= 1'b1;
            busy_r  <= 1'b1;
            last_r  <= (NUM == 1);
          end else begin
            valid_r <= 1'b0;
          end
        end
        ST_STREAM: begin
          if (final_s) begin
            idx_r <= '0;
            // A done_i on the closing handshake restarts without a bubble
            if (done_i) begin
              snap_r <= C;
              last_r <= (NUM == 1);
            end else begin
              state_r <= ST_IDLE;
              valid_r <= 1'b0;
              busy_r  <= 1'b0;
              last_r  <= 1'b0;
            end
          end else begin
            if (hs_s) begin
              idx_r  <= idx_nxt_s;
              last_r <= (idx_nxt_s == LAST_IDX);
            end else begin
              idx_r <= idx_r;
            end
            if (done_i) begin
              ovf_r <= 1'b1;
            end else begin
              ovf_r <= ovf_r;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          idx_r   <= '0;
          last_r  <= 1'b0;
        end
      endcase
    end
  end

  result_width_conv #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_conv (
    .acc  (elem_s),
    .data (data_s),
    .sat  (sat_s)
  );

  assign m.m_valid = valid_r;
  assign m.m_data  = data_s;
  assign m.m_last  = last_r;
  assign m.m_idx   = idx_r;
  assign m.sat_o   = sat_s;
  assign busy      = busy_r;
  assign overflow  = ovf_r;

endmodule

// File: tb/tb_matmul_result_drain.sv
// Self-checking bench for matmul_result_drain: vector table, directed corner cases,
// and a randomized run against a queue-based reference model.
module tb_matmul_result_drain;

  localparam int ACC_W = 32;
  localparam int OUT_W = 8;
  localparam int M     = 2;
  localparam int N     = 2;
  localparam int NUM   = M * N;
  localparam int IDX_W = $clog2(NUM) + 1;

  logic clk = 1'b0;
  logic rst;
  logic done_i;
  logic signed [M-1:0][N-1:0][ACC_W-1:0] c_in;
  logic busy;
  logic overflow;

  matmul_result_drain_if #(.OUT_W(OUT_W), .IDX_W(IDX_W)) bus ();

  matmul_result_drain #(
    .ACC_W (ACC_W), .OUT_W (OUT_W), .M (M), .N (N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .done_i   (done_i),
    .C        (c_in),
    .busy     (busy),
    .overflow (overflow),
    .m        (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint data;
    int     idx;
    bit     last;
    bit     sat;
  } word_t;

  typedef struct packed {
    logic [3:0][31:0] c;
    logic [3:0][31:0] d;
    logic [3:0]       s;
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  int    cur [4];
  word_t q [$];
  bit    m_ovf = 1'b0;
  vec_t  tbl [4];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Element narrowing from the rules: clamp to signed OUT_W range, or wrap modulo 2^OUT_W
  function automatic void conv(input longint a, output longint d, output bit s);
    longint half;
    longint full;
    half = longint'(1) << (OUT_W - 1);
    full = longint'(1) << OUT_W;
`ifdef RESULT_SAT_EN
    if (a > half - 1) begin
      d = half - 1; s = 1'b1;
    end else if (a < -half) begin
      d = -half; s = 1'b1;
    end else begin
      d = a; s = 1'b0;
    end
`else
    d = (((a + half) % full) + full) % full - half;
    s = 1'b0;
`endif
  endfunction

  function automatic vec_t mk(input int c0, c1, c2, c3, d0, d1, d2, d3,
                              input bit s0, s1, s2, s3);
    vec_t v;
    v.c[0] = c0; v.c[1] = c1; v.c[2] = c2; v.c[3] = c3;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    v.s[0] = s0; v.s[1] = s1; v.s[2] = s2; v.s[3] = s3;
    return v;
  endfunction

  task automatic model_update(input bit r, input bit d, input bit rdy);
    word_t w;
    if (r) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (d) begin
        if (q.size() == 0) begin
          for (int i = 0; i < NUM; i++) begin
            conv(longint'(cur[i]), w.data, w.sat);
            w.idx  = i;
            w.last = (i == NUM - 1);
            q.push_back(w);
          end
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic scoreboard();
    chk("valid", longint'(bus.m_valid), longint'(q.size() != 0));
    chk("busy", longint'(busy), longint'(q.size() != 0));
    chk("overflow", longint'(overflow), longint'(m_ovf));
    if (q.size() != 0) begin
      chk("data", longint'($signed(bus.m_data)), q[0].data);
      chk("idx", longint'(bus.m_idx), longint'(q[0].idx));
      chk("last", longint'(bus.m_last), longint'(q[0].last));
      chk("sat", longint'(bus.sat_o), longint'(q[0].sat));
    end
  endtask

  // Drive inputs for the next edge, advance the model, then compare after the edge
  task automatic tick(input bit r, input bit d, input bit rdy);
    rst         = r;
    done_i      = d;
    bus.m_ready = rdy;
    for (int i = 0; i < NUM; i++) c_in[i / N][i % N] = ACC_W'(cur[i]);
    model_update(r, d, rdy);
    @(posedge clk);
    #1;
    scoreboard();
  endtask

  task automatic set_cur(input int a, b, c, d);
    cur[0] = a; cur[1] = b; cur[2] = c; cur[3] = d;
  endtask

  initial begin
    int n;
    longint dv;
    bit     sv;

    tbl[0] = mk(1, 2, 3, 4, 1, 2, 3, 4, 0, 0, 0, 0);
    tbl[2] = mk(5, 6, 7, 8, 5, 6, 7, 8, 0, 0, 0, 0);
`ifdef RESULT_SAT_EN
    tbl[1] = mk(300, -300, 127, -128, 127, -128, 127, -128, 1, 1, 0, 0);
    tbl[3] = mk(-1, 128, -129, 256, -1, 127, -128, 127, 0, 1, 1, 1);
`else
    tbl[1] = mk(300, -300, 127, -128, 44, -44, 127, -128, 0, 0, 0, 0);
    tbl[3] = mk(-1, 128, -129, 256, -1, -128, 127, 0, 0, 0, 0, 0);
`endif

    set_cur(0, 0, 0, 0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    chk("rst_data", longint'($signed(bus.m_data)), 0);
    chk("rst_idx", longint'(bus.m_idx), 0);
    chk("rst_last", longint'(bus.m_last), 0);
    chk("rst_sat", longint'(bus.sat_o), 0);
    tick(1'b0, 1'b0, 1'b1);

    // Table-driven full drains with ready held high
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < NUM; i++) cur[i] = int'(tbl[k].c[i]);
      tick(1'b0, 1'b1, 1'b1);
      for (int j = 0; j < NUM; j++) begin
        dv = longint'(int'(tbl[k].d[j]));
        chk("tbl_data", longint'($signed(bus.m_data)), dv);
        chk("tbl_sat", longint'(bus.sat_o), longint'(tbl[k].s[j]));
        chk("tbl_last", longint'(bus.m_last), longint'(j == NUM - 1));
        tick(1'b0, 1'b0, 1'b1);
      end
      chk("tbl_busy_end", longint'(busy), 0);
    end

    // Backpressure: word 1 held three cycles, seven valid cycles in total
    set_cur(1, 2, 3, 4);
    n = 0;
    tick(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (bus.m_valid) n++;
      if (i <= 3) chk("bp_hold", longint'($signed(bus.m_data)), 1);
      tick(1'b0, 1'b0, i >= 3);
    end
    chk("bp_valid_cycles", longint'(n), 7);

    // Overflow: second done_i mid-drain is dropped
    set_cur(1, 2, 3, 4);
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    set_cur(9, 9, 9, 9);
    tick(1'b0, 1'b1, 1'b1);
    chk("ovf_set", longint'(overflow), 1);
    chk("ovf_data", longint'($signed(bus.m_data)), 3);
    tick(1'b0, 1'b0, 1'b1);
    chk("ovf_data4", longint'($signed(bus.m_data)), 4);
    tick(1'b0, 1'b0, 1'b1);
    chk("ovf_sticky", longint'(overflow), 1);

    // Reset mid-stream at idx 2
    set_cur(1, 2, 3, 4);
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    chk("mid_idx", longint'(bus.m_idx), 2);
    tick(1'b1, 1'b0, 1'b1);
    chk("mid_rst_valid", longint'(bus.m_valid), 0);
    chk("mid_rst_busy", longint'(busy), 0);
    chk("mid_rst_idx", longint'(bus.m_idx), 0);
    chk("mid_rst_ovf", longint'(overflow), 0);
    tick(1'b0, 1'b1, 1'b0);
    chk("restart_data", longint'($signed(bus.m_data)), 1);
    chk("restart_idx", longint'(bus.m_idx), 0);
    for (int i = 0; i < NUM; i++) tick(1'b0, 1'b0, 1'b1);

    // Back-to-back: done_i on the final handshake edge
    set_cur(1, 2, 3, 4);
    tick(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1);
    chk("b2b_last", longint'(bus.m_last), 1);
    set_cur(5, 6, 7, 8);
    tick(1'b0, 1'b1, 1'b1);
    chk("b2b_valid", longint'(bus.m_valid), 1);
    chk("b2b_data", longint'($signed(bus.m_data)), 5);
    chk("b2b_idx", longint'(bus.m_idx), 0);
    chk("b2b_ovf", longint'(overflow), 0);
    for (int i = 0; i < NUM; i++) tick(1'b0, 1'b0, 1'b1);

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      for (int e = 0; e < NUM; e++) cur[e] = int'($urandom_range(0, 1000)) - 500;
      sv = ($urandom_range(0, 149) == 0);
      tick(sv, $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
